// File: rtl/tag_compare.sv
// DRAM-cache tag-check stage: classifies one R-channel line against its request
// descriptor and dispatches to the ROB, the memory-side AR/AW/W FIFOs or the fill arbiter.
module tag_compare #(
    parameter int ADDR_W   = 64,
    parameter int DATA_W   = 512,
    parameter int ID_W     = 16,
    parameter int TAG_S    = 64,
    parameter int TAG_W    = 16,
    parameter int INDEX_W  = 10,
    parameter int OFFSET_W = 38,
    parameter int TID_W    = 10
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [ID_W-1:0]           rid_i,
    input  logic [TAG_S+DATA_W-1:0]   rdata_i,
    input  logic                      rvalid_i,
    output logic                      rready_o,
    input  logic                      tag_fifo_aempty_i,
    output logic                      tag_fifo_rden_o,
    input  logic [TID_W+ADDR_W:0]     tag_fifo_data_i,
    input  logic                      wbuffer_aempty_i,
    output logic                      wbuffer_rden_o,
    input  logic [DATA_W-1:0]         wbuffer_data_i,
    input  logic                      rob_afull_i,
    output logic                      rob_wren_o,
    output logic [TID_W+DATA_W-1:0]   rob_data_o,
    input  logic                      ar_fifo_afull_i,
    output logic                      ar_fifo_wren_o,
    output logic [TID_W+ADDR_W-1:0]   ar_fifo_data_o,
    input  logic                      aw_fifo_afull_i,
    output logic                      aw_fifo_wren_o,
    output logic [ADDR_W-1:0]         aw_fifo_data_o,
    input  logic                      w_fifo_afull_i,
    output logic                      w_fifo_wren_o,
    output logic [DATA_W-1:0]         w_fifo_data_o,
    input  logic                      fill_ready_i,
    output logic                      fill_valid_o,
    output logic [ADDR_W+DATA_W-1:0]  fill_data_o
);

    typedef enum logic [2:0] {S_IDLE, S_RHIT, S_RMISS, S_WHIT, S_WMISS} state_t;

    state_t state_q, state_d;

    logic [DATA_W-1:0] line_q, line_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [TID_W-1:0]  tid_q, tid_d;
    logic [TAG_W-1:0]  vtag_q, vtag_d;
    logic              wb_q, wb_d;

    logic [TAG_S-1:0]  in_tagword;
    logic              in_valid, in_dirty, in_wr, in_hit, in_wb;
    logic [TAG_W-1:0]  in_stag, in_atag;
    logic              accept, victim_ok, ar_commit;
    logic              unused_bits;

    assign in_tagword = rdata_i[DATA_W +: TAG_S];
    assign in_valid   = in_tagword[TAG_S-1];
    assign in_dirty   = in_tagword[TAG_S-2];
    assign in_stag    = in_tagword[TAG_S-3 -: TAG_W];
    assign in_atag    = tag_fifo_data_i[ADDR_W-1 -: TAG_W];
    assign in_wr      = tag_fifo_data_i[TID_W+ADDR_W];
    assign in_hit     = in_valid && (in_stag == in_atag);
    assign in_wb      = in_valid && in_dirty && !in_hit;

    // Nothing is popped while reset is held, so a reset cycle never loses a descriptor.
    assign accept     = !rst_n && (state_q == S_IDLE) && rvalid_i && !tag_fifo_aempty_i;
    assign victim_ok  = !wb_q || (!aw_fifo_afull_i && !w_fifo_afull_i);
    assign ar_commit  = !ar_fifo_afull_i && victim_ok;

    assign unused_bits = ^{rid_i, wbuffer_aempty_i, in_tagword[TAG_S-3-TAG_W:0]};

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q <= S_IDLE;
            line_q  <= '0;
            wdata_q <= '0;
            addr_q  <= '0;
            tid_q   <= '0;
            vtag_q  <= '0;
            wb_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            line_q  <= line_d;
            wdata_q <= wdata_d;
            addr_q  <= addr_d;
            tid_q   <= tid_d;
            vtag_q  <= vtag_d;
            wb_q    <= wb_d;
        end
    end

    always_comb begin
        line_d  = line_q;
        wdata_d = wdata_q;
        addr_d  = addr_q;
        tid_d   = tid_q;
        vtag_d  = vtag_q;
        wb_d    = wb_q;
        state_d = state_q;
        if (accept) begin
            line_d  = rdata_i[DATA_W-1:0];
            addr_d  = tag_fifo_data_i[ADDR_W-1:0];
            tid_d   = tag_fifo_data_i[ADDR_W +: TID_W];
            vtag_d  = in_stag;
            wb_d    = in_wb;
            if (in_wr) wdata_d = wbuffer_data_i;
        end
        case (state_q)
            S_IDLE:  if (accept) state_d = in_wr ? (in_hit ? S_WHIT : S_WMISS)
                                                 : (in_hit ? S_RHIT : S_RMISS);
            S_RHIT:  if (!rob_afull_i) state_d = S_IDLE;
            S_RMISS: if (ar_commit) state_d = S_IDLE;
            S_WHIT:  if (fill_ready_i) state_d = S_IDLE;
            S_WMISS: if (victim_ok && fill_ready_i) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rready_o        = accept;
        tag_fifo_rden_o = accept;
        wbuffer_rden_o  = accept && in_wr;
        rob_wren_o      = 1'b0;
        ar_fifo_wren_o  = 1'b0;
        aw_fifo_wren_o  = 1'b0;
        w_fifo_wren_o   = 1'b0;
        fill_valid_o    = 1'b0;
        if (!rst_n) begin
            case (state_q)
                S_RHIT:  rob_wren_o = !rob_afull_i;
                S_RMISS: begin
                    ar_fifo_wren_o = ar_commit;
                    aw_fifo_wren_o = ar_commit && wb_q;
                    w_fifo_wren_o  = ar_commit && wb_q;
                end
                S_WHIT:  fill_valid_o = 1'b1;
                S_WMISS: begin
                    fill_valid_o   = victim_ok;
                    aw_fifo_wren_o = victim_ok && fill_ready_i && wb_q;
                    w_fifo_wren_o  = victim_ok && fill_ready_i && wb_q;
                end
                default: ;
            endcase
        end
    end

    assign rob_data_o     = {tid_q, line_q};
    assign ar_fifo_data_o = {tid_q, addr_q};
    assign aw_fifo_data_o = {vtag_q, addr_q[OFFSET_W +: INDEX_W], {OFFSET_W{1'b0}}};
    assign w_fifo_data_o  = line_q;
    assign fill_data_o    = {addr_q, wdata_q};

endmodule

// File: tb/tb_tag_compare.sv
// Scoreboard bench for tag_compare: directed requests push expected pushes into
// per-channel queues, and a negedge monitor pops and compares each DUT push.
module tb_tag_compare;

    localparam logic [63:0] ADDR = 64'h0003_0040_0000_0000;
    localparam logic [63:0] VICT = 64'h0007_0040_0000_0000;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [15:0]  rid_i = '0;
    logic [575:0] rdata_i = '0;
    logic         rvalid_i = 1'b0;
    logic         rready_o;
    logic         tag_fifo_aempty_i = 1'b1;
    logic         tag_fifo_rden_o;
    logic [74:0]  tag_fifo_data_i = '0;
    logic         wbuffer_aempty_i = 1'b0;
    logic         wbuffer_rden_o;
    logic [511:0] wbuffer_data_i = '0;
    logic         rob_afull_i = 1'b0;
    logic         rob_wren_o;
    logic [521:0] rob_data_o;
    logic         ar_fifo_afull_i = 1'b0;
    logic         ar_fifo_wren_o;
    logic [73:0]  ar_fifo_data_o;
    logic         aw_fifo_afull_i = 1'b0;
    logic         aw_fifo_wren_o;
    logic [63:0]  aw_fifo_data_o;
    logic         w_fifo_afull_i = 1'b0;
    logic         w_fifo_wren_o;
    logic [511:0] w_fifo_data_o;
    logic         fill_ready_i = 1'b1;
    logic         fill_valid_o;
    logic [575:0] fill_data_o;

    int total = 0;
    int bad   = 0;

    logic [521:0] robQ[$];
    logic [73:0]  arQ[$];
    logic [63:0]  awQ[$];
    logic [511:0] wQ[$];
    logic [575:0] fillQ[$];

    logic [521:0] heldRob;
    logic [575:0] heldFill;

    tag_compare dut (
        .clk(clk), .rst_n(rst),
        .rid_i(rid_i), .rdata_i(rdata_i), .rvalid_i(rvalid_i), .rready_o(rready_o),
        .tag_fifo_aempty_i(tag_fifo_aempty_i), .tag_fifo_rden_o(tag_fifo_rden_o),
        .tag_fifo_data_i(tag_fifo_data_i),
        .wbuffer_aempty_i(wbuffer_aempty_i), .wbuffer_rden_o(wbuffer_rden_o),
        .wbuffer_data_i(wbuffer_data_i),
        .rob_afull_i(rob_afull_i), .rob_wren_o(rob_wren_o), .rob_data_o(rob_data_o),
        .ar_fifo_afull_i(ar_fifo_afull_i), .ar_fifo_wren_o(ar_fifo_wren_o),
        .ar_fifo_data_o(ar_fifo_data_o),
        .aw_fifo_afull_i(aw_fifo_afull_i), .aw_fifo_wren_o(aw_fifo_wren_o),
        .aw_fifo_data_o(aw_fifo_data_o),
        .w_fifo_afull_i(w_fifo_afull_i), .w_fifo_wren_o(w_fifo_wren_o),
        .w_fifo_data_o(w_fifo_data_o),
        .fill_ready_i(fill_ready_i), .fill_valid_o(fill_valid_o), .fill_data_o(fill_data_o)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] mkTag(input logic v, input logic d, input logic [15:0] t);
        return {v, d, t, 46'b0};
    endfunction

    task automatic checkOutput(input string name, input logic [1023:0] act, input logic [1023:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [1023:0] act);
        total++;
        bad++;
        $display("[TB] FAIL %s: unexpected push %0h expected none", name, act);
    endtask

    // Monitor: every DUT push is matched against the head of its channel queue.
    always @(negedge clk) begin
        if (!rst) begin
            if (rob_wren_o) begin
                if (robQ.size() == 0) unexpected("rob", rob_data_o);
                else checkOutput("rob", rob_data_o, robQ.pop_front());
            end
            if (ar_fifo_wren_o) begin
                if (arQ.size() == 0) unexpected("ar", ar_fifo_data_o);
                else checkOutput("ar", ar_fifo_data_o, arQ.pop_front());
            end
            if (aw_fifo_wren_o) begin
                if (awQ.size() == 0) unexpected("aw", aw_fifo_data_o);
                else checkOutput("aw", aw_fifo_data_o, awQ.pop_front());
            end
            if (w_fifo_wren_o) begin
                if (wQ.size() == 0) unexpected("w", w_fifo_data_o);
                else checkOutput("w", w_fifo_data_o, wQ.pop_front());
            end
            if (fill_valid_o && fill_ready_i) begin
                if (fillQ.size() == 0) unexpected("fill", fill_data_o);
                else checkOutput("fill", fill_data_o, fillQ.pop_front());
            end
        end
    end

    // Called at posedge+1; presents one R beat plus descriptor and checks the pops.
    task automatic applyStimulus(input logic wr, input logic [9:0] tid, input logic [63:0] addr,
                                 input logic [63:0] tagword, input logic [511:0] line,
                                 input logic [511:0] wdata);
        rdata_i           = {tagword, line};
        tag_fifo_data_i   = {wr, tid, addr};
        wbuffer_data_i    = wdata;
        rvalid_i          = 1'b1;
        tag_fifo_aempty_i = 1'b0;
        @(negedge clk);
        checkOutput("rready", rready_o, 1);
        checkOutput("tag_rden", tag_fifo_rden_o, 1);
        checkOutput("wbuf_rden", wbuffer_rden_o, wr);
        @(posedge clk); #1;
        rvalid_i          = 1'b0;
        tag_fifo_aempty_i = 1'b1;
    endtask

    task automatic waitDrain();
        int n = 0;
        while ((robQ.size() + arQ.size() + awQ.size() + wQ.size() + fillQ.size()) != 0 && n < 40) begin
            @(posedge clk);
            n++;
        end
        total++;
        if (n >= 40) begin
            bad++;
            $display("[TB] FAIL drain_timeout: %0d pushes outstanding expected 0",
                     robQ.size() + arQ.size() + awQ.size() + wQ.size() + fillQ.size());
            robQ.delete(); arQ.delete(); awQ.delete(); wQ.delete(); fillQ.delete();
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_strobes", {rready_o, tag_fifo_rden_o, wbuffer_rden_o, rob_wren_o,
                    ar_fifo_wren_o, aw_fifo_wren_o, w_fifo_wren_o, fill_valid_o}, 0);
        checkOutput("reset_fill_data", fill_data_o, 0);
        checkOutput("reset_rob_data", rob_data_o, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        $display("[TB] no pop while tag fifo empty");
        rvalid_i = 1'b1;
        @(negedge clk);
        checkOutput("empty_no_pop", {rready_o, tag_fifo_rden_o}, 0);
        @(posedge clk); #1;
        rvalid_i = 1'b0;

        $display("[TB] read hit");
        robQ.push_back({10'd1, 512'hF});
        applyStimulus(1'b0, 10'd1, ADDR, mkTag(1, 1, 16'h3), 512'hF, 512'h0);
        @(negedge clk);
        checkOutput("rd_hit_cycle2", rob_wren_o, 1);
        waitDrain();

        $display("[TB] read miss dirty victim");
        arQ.push_back({10'd2, ADDR});
        awQ.push_back(VICT);
        wQ.push_back(512'h10);
        applyStimulus(1'b0, 10'd2, ADDR, mkTag(1, 1, 16'h7), 512'h10, 512'h0);
        @(negedge clk);
        checkOutput("rd_miss_one_cycle", {ar_fifo_wren_o, aw_fifo_wren_o, w_fifo_wren_o}, 3'b111);
        waitDrain();

        $display("[TB] write hit");
        fillQ.push_back({ADDR, 512'hE});
        applyStimulus(1'b1, 10'd5, ADDR, mkTag(1, 0, 16'h3), 512'h0, 512'hE);
        waitDrain();

        $display("[TB] write miss dirty victim with W fifo full");
        w_fifo_afull_i = 1'b1;
        awQ.push_back(VICT);
        wQ.push_back(512'h5);
        fillQ.push_back({ADDR, 512'h9});
        applyStimulus(1'b1, 10'd6, ADDR, mkTag(1, 1, 16'h7), 512'h5, 512'h9);
        repeat (2) begin
            @(negedge clk);
            checkOutput("wr_miss_wfull_hold", {fill_valid_o, aw_fifo_wren_o}, 0);
        end
        @(posedge clk); #1;
        w_fifo_afull_i = 1'b0;
        @(negedge clk);
        checkOutput("wr_miss_together", {fill_valid_o, aw_fifo_wren_o, w_fifo_wren_o}, 3'b111);
        waitDrain();

        $display("[TB] clean misses");
        arQ.push_back({10'd3, ADDR});
        applyStimulus(1'b0, 10'd3, ADDR, mkTag(0, 1, 16'h7), 512'h33, 512'h0);
        waitDrain();
        fillQ.push_back({ADDR, 512'h22});
        applyStimulus(1'b1, 10'd4, ADDR, mkTag(0, 1, 16'h7), 512'h44, 512'h22);
        waitDrain();

        $display("[TB] ROB backpressure");
        rob_afull_i = 1'b1;
        robQ.push_back({10'd4, 512'hAB});
        applyStimulus(1'b0, 10'd4, ADDR, mkTag(1, 0, 16'h3), 512'hAB, 512'h0);
        heldRob = {10'd4, 512'hAB};
        repeat (3) begin
            @(negedge clk);
            checkOutput("rob_bp_wren", rob_wren_o, 0);
            checkOutput("rob_bp_data", rob_data_o, heldRob);
        end
        @(posedge clk); #1;
        rob_afull_i = 1'b0;
        waitDrain();

        $display("[TB] fill backpressure");
        fill_ready_i = 1'b0;
        fillQ.push_back({ADDR, 512'hCD});
        applyStimulus(1'b1, 10'd7, ADDR, mkTag(1, 1, 16'h3), 512'h0, 512'hCD);
        heldFill = {ADDR, 512'hCD};
        repeat (2) begin
            @(negedge clk);
            checkOutput("fill_bp_valid", fill_valid_o, 1);
            checkOutput("fill_bp_data", fill_data_o, heldFill);
        end
        @(posedge clk); #1;
        fill_ready_i = 1'b1;
        waitDrain();

        $display("[TB] reset during write hit");
        fill_ready_i = 1'b0;
        applyStimulus(1'b1, 10'd8, ADDR, mkTag(1, 0, 16'h3), 512'h0, 512'h77);
        @(negedge clk);
        checkOutput("whit_before_reset", fill_valid_o, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        checkOutput("whit_in_reset", fill_valid_o, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        fill_ready_i = 1'b1;
        @(negedge clk);
        checkOutput("whit_after_reset", fill_valid_o, 0);
        checkOutput("fill_data_cleared", fill_data_o, 0);
        repeat (4) @(posedge clk);
        #1;

        $display("[TB] test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation did not finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
